// File: rtl/seq_serializer.sv
// rtl/seq_serializer.sv - parallel-to-serial stage with a one-entry holding buffer
module seq_serializer #(
    parameter int DATA_W     = 8,
    parameter int MSB_FIRST  = 1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_bit_en,
    output logic              o_seq_out,
    output logic              o_bit_valid,
    output logic              o_word_done,
    output logic              o_busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] hold_reg;
    logic              hold_full;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic [CNT_W-1:0]  cnt;
    logic              word_done;
    logic              shift_tick;
    logic              last_bit;
    logic              advance;
    logic              load;
    logic              accept;
    logic              head;

    // Handshake and framing decisions derived from the current registers.
    always_comb begin
        o_ready    = !hold_full && !i_reset;
        accept     = i_valid && o_ready;
        shift_tick = (state == SHIFT) && i_bit_en;
        last_bit   = shift_tick && (cnt == CNT_LAST);
        advance    = shift_tick && (cnt != CNT_LAST);
        // A held word moves into the shifter whenever the shifter is free or
        // is giving up its last bit on this edge, so words stream gap-free.
        load       = hold_full && ((state == IDLE) || last_bit);
        head       = (MSB_FIRST != 0) ? shift_reg[DATA_W-1] : shift_reg[0];
        if (MSB_FIRST != 0) begin
            shift_next = {shift_reg[DATA_W-2:0], 1'b0};
        end else begin
            shift_next = {1'b0, shift_reg[DATA_W-1:1]};
        end
    end

    // FSM next-state: leave IDLE when a word is waiting, leave SHIFT when the
    // last bit goes out with nothing queued behind it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (hold_full) state_next = SHIFT;
            SHIFT:   if (last_bit && !hold_full) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Holding buffer, shift register, bit counter and word-done pulse.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
            shift_reg <= '0;
            cnt       <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= last_bit;
            // accept needs an empty buffer and load needs a full one, so the
            // two never collide and the held word is never overwritten.
            if (accept) begin
                hold_reg  <= i_data;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            if (load) begin
                shift_reg <= hold_reg;
                cnt       <= '0;
            end else if (advance) begin
                shift_reg <= shift_next;
                cnt       <= cnt + CNT_W'(1);
            end
        end
    end

    assign o_bit_valid = (state == SHIFT);
    assign o_seq_out   = (state == SHIFT) ? head : IDLE_LEVEL;
    assign o_word_done = word_done;
    assign o_busy      = (state == SHIFT) || hold_full;

endmodule

// File: tb/tb_seq_serializer.sv
// tb/tb_seq_serializer.sv - self-checking bench for seq_serializer (MSB-first and LSB-first)
module tb_seq_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       valid = 1'b0;
    logic       bit_en = 1'b1;

    logic a_ready, a_seq, a_bv, a_wd, a_busy;
    logic b_ready, b_seq, b_bv, b_wd, b_busy;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    seq_serializer #(.DATA_W(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_msb (
        .i_clk(clk), .i_reset(rst), .i_data(din), .i_valid(valid), .o_ready(a_ready),
        .i_bit_en(bit_en), .o_seq_out(a_seq), .o_bit_valid(a_bv), .o_word_done(a_wd),
        .o_busy(a_busy)
    );

    seq_serializer #(.DATA_W(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_lsb (
        .i_clk(clk), .i_reset(rst), .i_data(din), .i_valid(valid), .o_ready(b_ready),
        .i_bit_en(bit_en), .o_seq_out(b_seq), .o_bit_valid(b_bv), .o_word_done(b_wd),
        .o_busy(b_busy)
    );

    // Reference: the k-th serial bit of a word, in order of transmission.
    function automatic logic exp_bit(input logic [7:0] w, input int k, input bit msb);
        return msb ? w[7-k] : w[k];
    endfunction

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        vectors++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_reset got %b exp 0", a_ready); end
        vectors++; if (a_bv !== 1'b0 || b_bv !== 1'b0) begin errors++; $display("FAIL reset_bit_valid got %b/%b exp 0/0", a_bv, b_bv); end
        vectors++; if (a_seq !== 1'b0 || b_seq !== 1'b0) begin errors++; $display("FAIL reset_seq_out got %b/%b exp 0/0", a_seq, b_seq); end
        vectors++; if (a_wd !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL reset_done_busy got %b/%b exp 0/0", a_wd, a_busy); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        vectors++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b/%b exp 1/1", a_ready, b_ready); end
        vectors++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy_after got %b exp 0", a_busy); end
        tick();
    endtask

    task automatic test_single(input logic [7:0] w);
        valid = 1'b1; din = w;
        tick();
        valid = 1'b0;
        vectors++; if (a_bv !== 1'b0 || a_ready !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL single_held bv/ready/busy got %b%b%b exp 001", a_bv, a_ready, a_busy); end
        for (int k = 0; k < 8; k++) begin
            tick();
            vectors++; if (a_bv !== 1'b1 || b_bv !== 1'b1) begin errors++; $display("FAIL single_bv k=%0d got %b/%b exp 1/1", k, a_bv, b_bv); end
            vectors++; if (a_seq !== exp_bit(w, k, 1'b1)) begin errors++; $display("FAIL single_msb_bit k=%0d got %b exp %b", k, a_seq, exp_bit(w, k, 1'b1)); end
            vectors++; if (b_seq !== exp_bit(w, k, 1'b0)) begin errors++; $display("FAIL single_lsb_bit k=%0d got %b exp %b", k, b_seq, exp_bit(w, k, 1'b0)); end
            vectors++; if (a_wd !== 1'b0) begin errors++; $display("FAIL single_early_done k=%0d got %b exp 0", k, a_wd); end
        end
        tick();
        vectors++; if (a_wd !== 1'b1 || b_wd !== 1'b1) begin errors++; $display("FAIL single_done got %b/%b exp 1/1", a_wd, b_wd); end
        vectors++; if (a_bv !== 1'b0 || a_seq !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL single_idle bv/seq/busy got %b%b%b exp 000", a_bv, a_seq, a_busy); end
        tick();
        vectors++; if (a_wd !== 1'b0) begin errors++; $display("FAIL single_done_width got %b exp 0", a_wd); end
    endtask

    task automatic test_back_to_back(input logic [7:0] w1, input logic [7:0] w2);
        logic [7:0] w;
        int done_pos = -1;
        valid = 1'b1; din = w1;
        tick();
        valid = 1'b0;
        for (int p = 0; p < 16; p++) begin
            if (p == 1) begin valid = 1'b1; din = w2; end
            tick();
            valid = 1'b0;
            w = (p < 8) ? w1 : w2;
            vectors++; if (a_bv !== 1'b1 || b_bv !== 1'b1) begin errors++; $display("FAIL b2b_gap p=%0d got %b/%b exp 1/1", p, a_bv, b_bv); end
            vectors++; if (a_seq !== exp_bit(w, p % 8, 1'b1) || b_seq !== exp_bit(w, p % 8, 1'b0)) begin errors++; $display("FAIL b2b_bit p=%0d got %b/%b exp %b/%b", p, a_seq, b_seq, exp_bit(w, p % 8, 1'b1), exp_bit(w, p % 8, 1'b0)); end
            vectors++; if (a_ready !== ((p >= 1 && p < 8) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL b2b_ready p=%0d got %b exp %b", p, a_ready, (p >= 1 && p < 8) ? 1'b0 : 1'b1); end
            vectors++; if (a_wd !== (p == 8)) begin errors++; $display("FAIL b2b_done p=%0d got %b exp %b", p, a_wd, p == 8); end
            if (a_wd === 1'b1) done_pos = p;
        end
        tick();
        vectors++; if (a_wd !== 1'b1 || done_pos != 8) begin errors++; $display("FAIL b2b_second_done got %b first_at=%0d exp 1 first_at=8", a_wd, done_pos); end
        vectors++; if (a_bv !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b/%b exp 0/0", a_bv, a_busy); end
        tick();
    endtask

    task automatic test_gap(input logic [7:0] w1, input logic [7:0] w2);
        valid = 1'b1; din = w1;
        tick();
        valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            vectors++; if (a_seq !== exp_bit(w1, k, 1'b1) || b_seq !== exp_bit(w1, k, 1'b0)) begin errors++; $display("FAIL gap_w1_bit k=%0d got %b/%b exp %b/%b", k, a_seq, b_seq, exp_bit(w1, k, 1'b1), exp_bit(w1, k, 1'b0)); end
        end
        valid = 1'b1; din = w2;
        tick();
        valid = 1'b0;
        vectors++; if (a_bv !== 1'b0 || a_wd !== 1'b1 || a_busy !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL gap_cycle bv/wd/busy/ready got %b%b%b%b exp 0110", a_bv, a_wd, a_busy, a_ready); end
        for (int k = 0; k < 8; k++) begin
            tick();
            vectors++; if (a_bv !== 1'b1 || a_seq !== exp_bit(w2, k, 1'b1) || b_seq !== exp_bit(w2, k, 1'b0)) begin errors++; $display("FAIL gap_w2_bit k=%0d got bv=%b %b/%b exp bv=1 %b/%b", k, a_bv, a_seq, b_seq, exp_bit(w2, k, 1'b1), exp_bit(w2, k, 1'b0)); end
        end
        tick();
        vectors++; if (a_wd !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL gap_end wd/busy got %b%b exp 10", a_wd, a_busy); end
        tick();
    endtask

    task automatic test_rate(input logic [7:0] w);
        int k = 0;
        int done_cycle = -1;
        logic prev;
        bit_en = 1'b0;
        valid = 1'b1; din = w;
        tick();
        valid = 1'b0;
        tick();
        prev = a_seq;
        for (int c = 0; c < 40; c++) begin
            bit_en = (c % 4 == 3);
            tick();
            if (bit_en) k++;
            if (k < 8) begin
                vectors++; if (a_bv !== 1'b1 || a_seq !== exp_bit(w, k, 1'b1) || b_seq !== exp_bit(w, k, 1'b0)) begin errors++; $display("FAIL rate_bit c=%0d got bv=%b %b/%b exp bv=1 %b/%b", c, a_bv, a_seq, b_seq, exp_bit(w, k, 1'b1), exp_bit(w, k, 1'b0)); end
                if (!bit_en) begin
                    vectors++; if (a_seq !== prev) begin errors++; $display("FAIL rate_hold c=%0d got %b exp %b", c, a_seq, prev); end
                end
            end
            if (a_wd === 1'b1 && done_cycle < 0) done_cycle = c + 1;
            prev = a_seq;
            if (k >= 8) break;
        end
        vectors++; if (done_cycle != 32) begin errors++; $display("FAIL rate_word_cycles got %0d exp 32", done_cycle); end
        vectors++; if (a_bv !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL rate_idle got %b/%b exp 0/0", a_bv, a_busy); end
        bit_en = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        bit wd_seen = 1'b0;
        valid = 1'b1; din = 8'hB6;
        tick();
        valid = 1'b0;
        tick();
        valid = 1'b1; din = 8'h2C;
        tick();
        valid = 1'b0;
        tick();
        tick();
        vectors++; if (a_bv !== 1'b1 || a_ready !== 1'b0 || a_seq !== exp_bit(8'hB6, 3, 1'b1)) begin errors++; $display("FAIL rmid_pre bv/ready/seq got %b%b%b exp 10%b", a_bv, a_ready, a_seq, exp_bit(8'hB6, 3, 1'b1)); end
        #3;
        rst = 1'b1;
        #1;
        vectors++; if (a_bv !== 1'b0 || b_bv !== 1'b0 || a_seq !== 1'b0 || b_seq !== 1'b0) begin errors++; $display("FAIL rmid_async bv=%b/%b seq=%b/%b exp 0", a_bv, b_bv, a_seq, b_seq); end
        vectors++; if (a_busy !== 1'b0 || a_ready !== 1'b0 || a_wd !== 1'b0) begin errors++; $display("FAIL rmid_async busy/ready/wd got %b%b%b exp 000", a_busy, a_ready, a_wd); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        vectors++; if (a_ready !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL rmid_release ready/busy got %b%b exp 10", a_ready, a_busy); end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (a_wd === 1'b1 || b_wd === 1'b1 || a_bv === 1'b1 || b_bv === 1'b1) wd_seen = 1'b1;
        end
        vectors++; if (wd_seen) begin errors++; $display("FAIL rmid_discard activity after reset got 1 exp 0"); end
    endtask

    task automatic test_random(input int cycles);
        logic qa[$];
        logic qb[$];
        logic ea, eb;
        int accepted = 0;
        int dones = 0;
        logic [7:0] w;
        for (int c = 0; c < cycles + 60; c++) begin
            if (c < cycles) begin
                valid  = ($urandom_range(0, 2) != 0);
                w      = 8'($urandom);
                din    = w;
                bit_en = ($urandom_range(0, 3) != 0);
            end else begin
                valid  = 1'b0;
                bit_en = 1'b1;
            end
            #1;
            if (a_bv === 1'b1 && bit_en) begin
                vectors++;
                if (qa.size() == 0 || qb.size() == 0) begin
                    errors++; $display("FAIL rand_underflow c=%0d got bit with empty model queue exp none", c);
                end else begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    if (a_seq !== ea || b_seq !== eb) begin errors++; $display("FAIL rand_bit c=%0d got %b/%b exp %b/%b", c, a_seq, b_seq, ea, eb); end
                end
            end
            if (valid && a_ready === 1'b1) begin
                accepted++;
                for (int k = 0; k < 8; k++) begin
                    qa.push_back(exp_bit(din, k, 1'b1));
                    qb.push_back(exp_bit(din, k, 1'b0));
                end
            end
            tick();
            if (a_wd === 1'b1) dones++;
        end
        vectors++; if (qa.size() != 0 || a_busy !== 1'b0) begin errors++; $display("FAIL rand_drain left=%0d busy=%b exp 0/0", qa.size(), a_busy); end
        vectors++; if (dones != accepted) begin errors++; $display("FAIL rand_word_done got %0d exp %0d", dones, accepted); end
        vectors++; if (accepted < 10) begin errors++; $display("FAIL rand_coverage accepted %0d exp >=10", accepted); end
    endtask

    initial begin
        test_reset();
        test_single(8'hB6);
        test_back_to_back(8'hB6, 8'h2C);
        test_back_to_back(8'b1011_0110, 8'b1100_0000);
        test_gap(8'h5A, 8'hC3);
        test_rate(8'hF0);
        test_reset_mid();
        test_single(8'($urandom));
        test_random(600);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish exp finish before 200000");
        $fatal(1);
    end

endmodule
